current_loop_scheduler: RTL

//   Sequences the FOC current loop (Clark/Park -> d/q PID -> anti-Park) once per PWM period.

---
 rtl/current_loop_scheduler.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/current_loop_scheduler.sv
// Once-per-PWM-period sequencer for the FOC current loop: ADC sample -> start pulse -> done,
// then latches U_alpha/U_beta, decimates a speed-loop trigger and traps overruns in a sticky fault.
//   state       | meaning
//   S_IDLE      | waiting for the period tick
//   S_WAIT_ADC  | tick seen, waiting for the phase-current sample
//   S_START     | one-cycle start pulse to the current loop
//   S_WAIT_DONE | current loop running, timeout counter advancing
//   S_LATCH     | new voltages presented, speed divider advanced
//   S_FAULT     | overrun/timeout, voltages zeroed until fault_clear_in
module current_loop_scheduler #(
    parameter int DATA_WIDTH     = 16,
    parameter int PERIOD_CYCLES  = 5000,
    parameter int TIMEOUT_CYCLES = 400,
    parameter int SPEED_DIV      = 10
) (
    input  logic                         sys_clk,
    input  logic                         reset_n,
    input  logic                         loop_enable_in,
    input  logic                         adc_sample_valid_in,
    output logic                         current_loop_enable_out,
    input  logic                         current_loop_done_in,
    input  logic signed [DATA_WIDTH-1:0] voltage_alpha_in,
    input  logic signed [DATA_WIDTH-1:0] voltage_beta_in,
    output logic signed [DATA_WIDTH-1:0] voltage_alpha_out,
    output logic signed [DATA_WIDTH-1:0] voltage_beta_out,
    output logic                         voltage_valid_out,
    output logic                         speed_loop_enable_out,
    output logic                         overrun_fault_out,
    input  logic                         fault_clear_in,
    output logic                         busy_out
);

    localparam int PW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(SPEED_DIV + 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0] SPEED_LAST  = SW'(SPEED_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ADC,
        S_START,
        S_WAIT_DONE,
        S_LATCH,
        S_FAULT
    } state_t;

    state_t state, state_nxt;

    logic [PW-1:0] period_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [SW-1:0] speed_cnt;
    logic signed [DATA_WIDTH-1:0] alpha_q, beta_q;
    logic tick, tmo_hit, latch_en, fault_entry;

    assign tick        = loop_enable_in && (period_cnt == PERIOD_LAST);
    assign tmo_hit     = (tmo_cnt == TMO_LAST);
    assign latch_en    = (state == S_WAIT_DONE) && current_loop_done_in && loop_enable_in;
    assign fault_entry = (state_nxt == S_FAULT) && (state != S_FAULT);

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt <= '0;
        end else if (!loop_enable_in || tick) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // tmo_cnt holds k-1 in the k-th WAIT_DONE cycle, so the hit fires after TIMEOUT_CYCLES cycles
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
        end else if (state == S_START) begin
            tmo_cnt <= '0;
        end else if (state == S_WAIT_DONE) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            speed_cnt <= '0;
        end else if (state == S_LATCH) begin
            speed_cnt <= (speed_cnt == SPEED_LAST) ? '0 : speed_cnt + 1'b1;
        end
    end

    // Zeroing the latch on fault entry keeps the SVPWM stage at zero voltage until a fresh run
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            alpha_q <= '0;
            beta_q  <= '0;
        end else if (fault_entry) begin
            alpha_q <= '0;
            beta_q  <= '0;
        end else if (latch_en) begin
            alpha_q <= voltage_alpha_in;
            beta_q  <= voltage_beta_in;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!loop_enable_in && (state != S_FAULT)) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:      if (tick) state_nxt = S_WAIT_ADC;
                S_WAIT_ADC: begin
                    if (tick)                     state_nxt = S_FAULT;
                    else if (adc_sample_valid_in) state_nxt = S_START;
                end
                S_START:     state_nxt = tick ? S_FAULT : S_WAIT_DONE;
                S_WAIT_DONE: begin
                    if (current_loop_done_in)  state_nxt = S_LATCH;
                    else if (tick || tmo_hit)  state_nxt = S_FAULT;
                end
                S_LATCH:     state_nxt = tick ? S_WAIT_ADC : S_IDLE;
                S_FAULT:     if (fault_clear_in) state_nxt = S_IDLE;
                default:     state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        current_loop_enable_out = (state == S_START);
        voltage_valid_out       = (state == S_LATCH);
        speed_loop_enable_out   = (state == S_LATCH) && (speed_cnt == SPEED_LAST);
        overrun_fault_out       = (state == S_FAULT);
        busy_out                = (state == S_WAIT_ADC) || (state == S_START) || (state == S_WAIT_DONE);
        voltage_alpha_out       = alpha_q;
        voltage_beta_out        = beta_q;
    end

endmodule
